gpio_pin_ctrl: RTL
==================

Name: gpio_pin_ctrl

Overview:
- Pad-side stage directly downstream of the GPIO register file.
- Consumes rf_gpio_datareg, rf_gpio_tristate and rf_gpio_interrupt_mask, and drives the pad output and output-enable.
- Synchronizes and glitch-filters the pad inputs to produce ro_gpio_pinstate for the register file's read path.
- Latches per-pin edge interrupts into a sticky status vector and drives a single interrupt line.

Parameters:
- WIDTH, 16: number of GPIO pins.
- SYNC_STAGES, 2: synchronizer flop depth, >=2.
- FILTER_LEN, 4: cycles a synchronized level must stay stable before it is accepted; >=1, where 1 means no filtering.
- IRQ_EDGE, 2: edge that raises an interrupt; 0 = rising, 1 = falling, 2 = both.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rf_gpio_datareg  in  WIDTH  output data from the register file.
- rf_gpio_tristate  in  WIDTH  1 = pin is an input (high-Z), 0 = pin is driven.
- rf_gpio_interrupt_mask  in  WIDTH  1 = interrupt enabled for the pin.
- irq_clear  in  WIDTH  one-cycle write-1-to-clear pulse from the register file.
- gpio_pin_in  in  WIDTH  asynchronous pad input.
- gpio_pin_out  out  WIDTH  pad output data.
- gpio_pin_oe  out  WIDTH  pad output enable, 1 = drive.
- ro_gpio_pinstate  out  WIDTH  filtered, synchronized pin level.
- irq_status  out  WIDTH  sticky per-pin pending interrupt.
- gpio_irq  out  1  combined interrupt request.

Behaviour:
- Reset values: all flops clear; gpio_pin_out=0, gpio_pin_oe=0 (all pins input), ro_gpio_pinstate=0, irq_status=0, gpio_irq=0. Filter counters and synchronizer flops are also 0.
- Output path:
  - gpio_pin_out is rf_gpio_datareg registered once.
  - gpio_pin_oe is ~rf_gpio_tristate registered once.
  - Latency is 1 cycle from the register file to the pad.
- Input path: every pin passes through the input path, including driven pins; the pad loopback is visible in pinstate.
- Synchronizer: SYNC_STAGES-flop chain per pin; s = last stage.
- Filter, per pin, counter cnt of clog2(FILTER_LEN)+1 bits:
  - s == pinstate: cnt <= 0.
  - s != pinstate and cnt < FILTER_LEN-1: cnt <= cnt+1.
  - s != pinstate and cnt == FILTER_LEN-1: pinstate <= s, cnt <= 0, and upd is pulsed that cycle.
  - A glitch shorter than FILTER_LEN cycles at s resets cnt and never reaches pinstate.
- Latency: a clean pad transition is visible on ro_gpio_pinstate SYNC_STAGES+FILTER_LEN rising edges after the first sampling edge (6 by default).
- Edge qualification: a rise is upd with s=1; a fall is upd with s=0. An edge qualifies per IRQ_EDGE.
- Status: irq_status[i] is set on the same edge that pinstate updates, if the edge qualifies and rf_gpio_interrupt_mask[i]=1.
  - Masked edges are discarded, not deferred.
  - The bit stays set until irq_clear[i]=1.
  - A set and a clear in the same cycle: set wins, so no event is lost.
  - Clearing a bit that is already 0 has no effect.
- gpio_irq = |(irq_status & rf_gpio_interrupt_mask).
  - Combinational from flops and register inputs.
  - Dropping a mask bit suppresses gpio_irq but keeps the pending status bit.
- Reset mid-operation: in-flight filter counts and pending status are discarded.
- Post-reset behaviour: a pad held high re-acquires pinstate=1 after the full latency. This produces a rising edge that sets status only if the mask is already enabled; the register file resets the mask to 0, so no spurious interrupt occurs.

Decomposition:
- Shared package gpio_pkg holds:
  - GPIO_WIDTH=16;
  - IRQ_EDGE_RISE=0, IRQ_EDGE_FALL=1, IRQ_EDGE_BOTH=2;
  - the tristate and mask polarity constants.
- Sub-module gpio_pin_filter: one pin's synchronizer, filter counter, pinstate flop and upd pulse. It is instantiated WIDTH times in a generate loop.
- Status, clear and irq logic stay in gpio_pin_ctrl.

Test Plan:
- Reset, then rf_gpio_tristate=16'h00FF, datareg=16'hA5A5 -> one cycle later gpio_pin_oe=16'hFF00 and gpio_pin_out=16'hA5A5.
- Mask=16'h0001, gpio_pin_in[0] 0->1 held -> ro_gpio_pinstate[0]=1 exactly 6 cycles later, irq_status=16'h0001 and gpio_irq=1 on the same edge.
- 3-cycle high pulse on gpio_pin_in[3] (FILTER_LEN=4) -> pinstate[3] stays 0 and irq_status stays 0.
- Pin 5 edge with mask[5]=0 -> pinstate[5] follows, irq_status[5]=0. Then set mask[5]=1 -> no late interrupt.
- Pending irq_status[0], then irq_clear=16'h0001 in the same cycle as a new qualifying edge on pin 0 -> irq_status[0] remains 1. A later lone clear -> 0 and gpio_irq=0.
- Pin 0 high with filter count at 2, assert reset for 1 cycle -> all outputs 0. Pinstate[0] returns to 1 after 6 cycles with no status set (mask=0).

Source files
------------

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants and helpers for the GPIO pad-side stage.
//               Holds the default pin count, the interrupt edge selector
//               encodings, the tristate / mask bit polarities and the edge
//               qualification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    localparam int GPIO_WIDTH = 16;

    // Interrupt edge selector encodings
    localparam int IRQ_EDGE_RISE = 0;
    localparam int IRQ_EDGE_FALL = 1;
    localparam int IRQ_EDGE_BOTH = 2;

    // Tristate bit value that makes a pin an input (pad not driven)
    localparam logic TRISTATE_INPUT = 1'b1;
    // Interrupt mask bit value that enables a pin's interrupt
    localparam logic MASK_ENABLE    = 1'b1;

    // An accepted level change is a rise when the new level is 1 and a
    // fall when it is 0; report whether that edge type raises an interrupt.
    function automatic logic edge_qualifies(input int irq_edge, input logic new_level);
        logic q;
        q = 1'b0;
        case (irq_edge)
            IRQ_EDGE_RISE: q = new_level;
            IRQ_EDGE_FALL: q = ~new_level;
            default:       q = 1'b1;
        endcase
        return q;
    endfunction

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_pin_filter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pin_filter
// Description : One pin of the GPIO input path: SYNC_STAGES-deep
//               synchronizer, stability counter and filtered level flop.
//               upd_o pulses in the cycle whose rising edge loads a new
//               filtered level; level_o is the synchronized level that is
//               being loaded at that edge.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               pin_i          - asynchronous pad input
//               pinstate_o     - filtered, synchronized level
//               upd_o          - pinstate_o changes at the next rising edge
//               level_o        - synchronized (last stage) level
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pin_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic pinstate_o,
    output logic upd_o,
    output logic level_o
);

    localparam int                 CNT_W   = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   pinstate_q;
    logic                   pinstate_d;
    logic                   w_s;
    logic                   w_upd;

    assign w_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], pin_i};
        cnt_d      = cnt_q;
        pinstate_d = pinstate_q;
        w_upd      = 1'b0;
        if (w_s == pinstate_q) begin
            // Any return to the accepted level restarts the stability count,
            // so a glitch shorter than FILTER_LEN cycles is never accepted.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            pinstate_d = w_s;
            cnt_d      = '0;
            w_upd      = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            pinstate_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            pinstate_q <= pinstate_d;
        end
    end

    assign pinstate_o = pinstate_q;
    assign upd_o      = w_upd;
    assign level_o    = w_s;

endmodule : gpio_pin_filter
`default_nettype wire

// File: rtl/gpio_pin_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pin_ctrl
// Description : Pad-side GPIO stage. Registers the data and output enable
//               toward the pad, filters the pad inputs into
//               ro_gpio_pinstate, latches qualifying edges into sticky
//               per-pin status bits and drives a combined interrupt line.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               rf_gpio_datareg         - output data from the register file
//               rf_gpio_tristate        - 1 = pin is an input (high-Z)
//               rf_gpio_interrupt_mask  - 1 = pin interrupt enabled
//               irq_clear               - write-1-to-clear status pulse
//               gpio_pin_in             - asynchronous pad inputs
//               gpio_pin_out            - pad output data
//               gpio_pin_oe             - pad output enable, 1 = drive
//               ro_gpio_pinstate        - filtered pin levels
//               irq_status              - sticky pending interrupts
//               gpio_irq                - combined interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pin_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int IRQ_EDGE    = IRQ_EDGE_BOTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rf_gpio_datareg,
    input  logic [WIDTH-1:0] rf_gpio_tristate,
    input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
    input  logic [WIDTH-1:0] irq_clear,
    input  logic [WIDTH-1:0] gpio_pin_in,
    output logic [WIDTH-1:0] gpio_pin_out,
    output logic [WIDTH-1:0] gpio_pin_oe,
    output logic [WIDTH-1:0] ro_gpio_pinstate,
    output logic [WIDTH-1:0] irq_status,
    output logic             gpio_irq
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] oe_d;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_d;
    logic [WIDTH-1:0] w_mask_en;
    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_set;

    // ------------------------------------------------------------------
    // Output path: one register stage from the register file to the pad
    // ------------------------------------------------------------------
    assign oe_d      = rf_gpio_tristate ^ {WIDTH{TRISTATE_INPUT}};
    assign w_mask_en = ~(rf_gpio_interrupt_mask ^ {WIDTH{MASK_ENABLE}});

    // ------------------------------------------------------------------
    // Input path: every pin is filtered, driven pins included, so the pad
    // loopback shows up in the pin state.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_filter (
            .clk        (clk),
            .reset      (reset),
            .pin_i      (gpio_pin_in[i]),
            .pinstate_o (ro_gpio_pinstate[i]),
            .upd_o      (w_upd[i]),
            .level_o    (w_level[i])
        );
    end

    // ------------------------------------------------------------------
    // Sticky status. Masked edges are dropped rather than remembered, and
    // a set coinciding with a clear wins so no event is lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_set[i] = w_upd[i] & w_mask_en[i] & edge_qualifies(IRQ_EDGE, w_level[i]);
        end
        status_d = (status_q & ~irq_clear) | w_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            oe_q     <= '0;
            status_q <= '0;
        end else begin
            out_q    <= rf_gpio_datareg;
            oe_q     <= oe_d;
            status_q <= status_d;
        end
    end

    assign gpio_pin_out = out_q;
    assign gpio_pin_oe  = oe_q;
    assign irq_status   = status_q;
    // The mask gates only the request line; pending status is preserved.
    assign gpio_irq     = |(status_q & w_mask_en);

endmodule : gpio_pin_ctrl
`default_nettype wire
